// File: rtl/n_restador_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Latency: n/a (definitions only).
// Backpressure: n/a.
//
// Holds the FSM state encoding and the NZCV flag bit positions. The flag
// positions are shared with the combinational adder and the ALU, so all
// three produce the same flag[3:0] layout.
package n_restador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

endpackage

// File: rtl/sumador_1_bit.sv
// 1-bit full adder cell.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   carry_in  - carry into this bit
//   a, b      - operand bits
//   sum       - a ^ b ^ carry_in
//   carry_out - majority(a, b, carry_in)
module sumador_1_bit (
  input  logic carry_in,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/n_restador_serial.sv
// Bit-serial N-bit two's-complement subtractor, C = A - B, LSB first.
// Latency: N+1 cycles from accepted start to the done cycle.
// Backpressure: start is accepted only in IDLE; start while busy is dropped.
//
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   start      - request pulse, sampled only when idle
//   A, B       - minuend / subtrahend, latched on accepted start
//   busy       - high in SHIFT and DONE
//   done       - one-cycle pulse, C and flag valid
//   C          - difference, held until the next accepted start
//   flag       - {N, Z, C(not borrow), V}
module n_restador_serial
  import n_restador_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] C,
  output logic [3:0]   flag
);

  localparam int CW = $clog2(N);

  state_t          state;
  state_t          state_nxt;
  logic [N-1:0]    a_reg;
  logic [N-1:0]    b_reg;
  logic            carry_reg;
  logic [CW-1:0]   cnt;

  logic            sum_bit;
  logic            cout_bit;
  logic            last_bit;
  logic [N-1:0]    c_nxt;

  // Subtraction as A + ~B + 1: the +1 comes from seeding carry_reg to 1.
  sumador_1_bit u_cell (
    .carry_in  (carry_reg),
    .a         (a_reg[cnt]),
    .b         (~b_reg[cnt]),
    .sum       (sum_bit),
    .carry_out (cout_bit)
  );

  assign last_bit = (cnt == CW'(N - 1));

  // Result word including the bit being produced this cycle. On the last
  // SHIFT cycle this is the final difference, which lets the flags be
  // registered on the edge into DONE so they are valid alongside done.
  always_comb begin
    c_nxt      = C;
    c_nxt[cnt] = sum_bit;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      C         <= '0;
      flag      <= 4'b0000;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= A;
            b_reg     <= B;
            carry_reg <= 1'b1;
            cnt       <= '0;
            C         <= '0;
          end
        end
        SHIFT: begin
          C         <= c_nxt;
          carry_reg <= cout_bit;
          cnt       <= cnt + CW'(1);
          if (last_bit) begin
            flag[FLAG_N] <= c_nxt[N-1];
            flag[FLAG_Z] <= (c_nxt == '0);
            flag[FLAG_C] <= cout_bit;
            // Overflow only when operand signs differ and the result sign
            // disagrees with the minuend.
            flag[FLAG_V] <= (a_reg[N-1] != b_reg[N-1]) &&
                            (c_nxt[N-1] != a_reg[N-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
